// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: decodes the 14-bit IR and walks each instruction
// through fetch, operand read, writeback or branch test, and counts retirements.
module control_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic [13:0] instruction_register,
    input  logic        bus_zero,
    output logic        pc_load_en,
    output logic        pc_sel,
    output logic        ir_load_en,
    output logic        rf_write_read,
    output logic [7:0]  rf_address,
    output logic        src_a_load_en,
    output logic        src_b_load_en,
    output logic [1:0]  bus_sel,
    output logic [2:0]  alu_op,
    output logic        halted,
    output logic [7:0]  retired
);

    // state     | meaning
    // IDLE      | waiting for run
    // FETCH     | load IR, advance PC
    // DECODE    | dispatch on instruction class
    // RD_A      | read rs1 into operand A
    // RD_B      | read rs2 into operand B
    // ALU_WB    | write ALU result to rd
    // LDI_WB    | write immediate to reg
    // BR_TEST   | read reg, load PC with target if zero
    // HALT      | stopped until reset

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, RD_A, RD_B, ALU_WB, LDI_WB, BR_TEST, HALT
    } state_t;

    localparam logic [2:0] A_PLUS_B = 3'd0;
    localparam logic [1:0] BUS_RF   = 2'd0;
    localparam logic [1:0] BUS_ALU  = 2'd1;
    localparam logic [1:0] BUS_IMM  = 2'd2;

    state_t     state;
    state_t     next_state;
    logic [1:0] ir_class;
    logic       retire;

    assign ir_class = instruction_register[13:12];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (run) next_state = FETCH;
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (ir_class)
                    2'b00:   next_state = RD_A;
                    2'b01:   next_state = LDI_WB;
                    2'b10:   next_state = BR_TEST;
                    default: next_state = instruction_register[11] ? HALT : FETCH;
                endcase
            end
            RD_A:    next_state = RD_B;
            RD_B:    next_state = ALU_WB;
            ALU_WB:  next_state = FETCH;
            LDI_WB:  next_state = FETCH;
            BR_TEST: next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pc_load_en    = 1'b0;
        pc_sel        = 1'b0;
        ir_load_en    = 1'b0;
        rf_write_read = 1'b0;
        rf_address    = 8'd0;
        src_a_load_en = 1'b0;
        src_b_load_en = 1'b0;
        bus_sel       = BUS_RF;
        alu_op        = A_PLUS_B;
        halted        = 1'b0;
        case (state)
            FETCH: begin
                ir_load_en = 1'b1;
                pc_load_en = 1'b1;
            end
            RD_A: begin
                rf_address    = {5'd0, instruction_register[5:3]};
                src_a_load_en = 1'b1;
            end
            RD_B: begin
                rf_address    = {5'd0, instruction_register[2:0]};
                src_b_load_en = 1'b1;
            end
            ALU_WB: begin
                rf_address    = {5'd0, instruction_register[8:6]};
                bus_sel       = BUS_ALU;
                alu_op        = instruction_register[11:9];
                rf_write_read = 1'b1;
            end
            LDI_WB: begin
                rf_address    = {5'd0, instruction_register[11:9]};
                bus_sel       = BUS_IMM;
                rf_write_read = 1'b1;
            end
            BR_TEST: begin
                rf_address = {5'd0, instruction_register[11:9]};
                pc_load_en = bus_zero;
                pc_sel     = bus_zero;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // A NOP retires straight out of DECODE; HALT never retires.
    assign retire = (state == ALU_WB) || (state == LDI_WB) || (state == BR_TEST) ||
                    ((state == DECODE) && (ir_class == 2'b11) && !instruction_register[11]);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            retired <= 8'd0;
        end else if (retire) begin
            retired <= retired + 8'd1;
        end
    end

endmodule
